// File: rtl/dds_pkg.sv
// Shared definitions for the multi-waveform DDS: waveform encodings,
// pipeline latency and the quarter-wave sine table generator.
// Optional feature macro: DDS_AMP_SCALE_EN (adds the amplitude-scaling stage).
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_SAW    = 2'd2,
    WAVE_TRI    = 2'd3
  } wave_e;

`ifdef DDS_AMP_SCALE_EN
  localparam int unsigned LATENCY = 4;
`else
  localparam int unsigned LATENCY = 3;
`endif

  localparam real PI = 3.14159265358979323846;

  // Quarter-wave entry i, sampled at the bin centre so both mirror halves
  // of the full wave come out exactly symmetric.
  function automatic int lut_entry(input int addr_w, input int data_w, input int i);
    real peak;
    real ang;
    peak = real'((1 << (data_w - 1)) - 1);
    ang  = (PI / 2.0) * (real'(i) + 0.5) / real'(1 << addr_w);
    return $rtoi(peak * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Registered quarter-wave sine ROM; returns the magnitude above mid-scale.
module dds_sine_lut
  import dds_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 14
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-2:0] mag
);

  localparam int unsigned MAG_W = DATA_W - 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [MAG_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_rom
    assign rom[i] = MAG_W'(lut_entry(int'(ADDR_W), int'(DATA_W), i));
  end

  // Synchronous table read
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) mag <= '0;
    else         mag <= rom[addr];
  end

endmodule

// File: rtl/dds_multiwave.sv
// Multi-waveform DDS: phase accumulator, offset, and sine/square/saw/triangle
// generation feeding an offset-binary DAC bus.
// Optional feature macro: DDS_AMP_SCALE_EN adds a gain stage (amp/256).
module dds_multiwave
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 14
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               cfg_load,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [PHASE_W-1:0] phase_ofs,
  input  logic [1:0]         wave_sel,
  input  logic [7:0]         amp,
  input  logic               phase_rst,
  input  logic               en,
  output logic [DATA_W-1:0]  da_data,
  output logic               da_valid
);

  localparam int unsigned      MAG_W  = DATA_W - 1;
  localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MID_M1 = MID - DATA_W'(1);
  localparam logic [DATA_W-1:0] FULL   = '1;

  logic [PHASE_W-1:0] fw_r;
  logic [PHASE_W-1:0] ofs_r;
  wave_e              sel_r;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ph_r;
  wave_e              sel1_r;
  logic [DATA_W-1:0]  t_c;
  logic [DATA_W-1:0]  u_c;
  logic [1:0]         q_c;
  logic [ADDR_W-1:0]  idx_c;
  logic [ADDR_W-1:0]  lut_addr_c;
  logic [DATA_W-1:0]  arith_c;
  logic [MAG_W-1:0]   mag;
  logic [DATA_W-1:0]  arith_r;
  logic               q1_r;
  wave_e              sel2_r;
  logic [DATA_W-1:0]  sample_r;
  logic [LATENCY:0]   vld_sr;

  // Shadow configuration registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fw_r  <= '0;
      ofs_r <= '0;
      sel_r <= WAVE_SINE;
    end else if (cfg_load) begin
      fw_r  <= freq_word;
      ofs_r <= phase_ofs;
      sel_r <= wave_e'(wave_sel);
    end
  end

  // S0: phase accumulator, clear beats advance
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)        acc <= '0;
    else if (phase_rst) acc <= '0;
    else if (en)        acc <= acc + fw_r;
  end

  // S1: offset phase with its waveform select kept alongside
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ph_r   <= '0;
      sel1_r <= WAVE_SINE;
    end else begin
      ph_r   <= acc + ofs_r;
      sel1_r <= sel_r;
    end
  end

  // S2 combinational: phase fields, mirrored LUT address, arithmetic waves
  always_comb begin
    t_c        = ph_r[PHASE_W-1 -: DATA_W];
    q_c        = ph_r[PHASE_W-1 -: 2];
    idx_c      = ph_r[PHASE_W-3 -: ADDR_W];
    lut_addr_c = q_c[0] ? ~idx_c : idx_c;
    u_c        = {t_c[DATA_W-2:0], 1'b0};
    arith_c    = '0;
    case (sel1_r)
      WAVE_SQUARE: arith_c = ph_r[PHASE_W-1] ? '0 : FULL;
      WAVE_SAW:    arith_c = t_c;
      WAVE_TRI:    arith_c = t_c[DATA_W-1] ? ~u_c : u_c;
      default:     arith_c = '0;
    endcase
  end

  dds_sine_lut #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_lut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .addr    (lut_addr_c),
    .mag     (mag)
  );

  // S2 registers running in parallel with the LUT read
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      arith_r <= '0;
      q1_r    <= 1'b0;
      sel2_r  <= WAVE_SINE;
    end else begin
      arith_r <= arith_c;
      q1_r    <= q_c[1];
      sel2_r  <= sel1_r;
    end
  end

  // S3: sine half-wave unfolding or arithmetic wave selection
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sample_r <= MID;
    end else if (sel2_r == WAVE_SINE) begin
      sample_r <= q1_r ? (MID_M1 - {1'b0, mag}) : (MID + {1'b0, mag});
    end else begin
      sample_r <= arith_r;
    end
  end

  // Valid flag tracks the enable of the accumulator step through every stage
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) vld_sr <= '0;
    else         vld_sr <= {vld_sr[LATENCY-1:0], en};
  end

  assign da_valid = vld_sr[LATENCY];

`ifdef DDS_AMP_SCALE_EN
  logic [7:0]               amp_r;
  logic signed [DATA_W:0]   dev_c;
  logic signed [DATA_W+9:0] prod_c;
  logic                     unused_sig;

  // Gain shadow register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)       amp_r <= '0;
    else if (cfg_load) amp_r <= amp;
  end

  // Signed deviation from mid-scale times unsigned gain
  always_comb begin
    dev_c  = $signed({1'b0, sample_r}) - $signed({1'b0, MID});
    prod_c = (DATA_W+10)'(dev_c) * (DATA_W+10)'($signed({1'b0, amp_r}));
  end

  // S4: rescaled sample, floor rounding via arithmetic shift
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) da_data <= MID;
    else         da_data <= MID + DATA_W'(prod_c >>> 8);
  end

  assign unused_sig = ^{ph_r, prod_c};
`else
  logic unused_sig;

  assign da_data    = sample_r;
  assign unused_sig = ^{amp, ph_r};
`endif

endmodule

// File: tb/tb_dds_multiwave.sv
// Self-checking bench for dds_multiwave: randomized and directed stimulus
// against a phase-domain reference model of the waveforms.
module tb_dds_multiwave;

`ifdef DDS_AMP_SCALE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam real PI_R = 3.14159265358979323846;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cfg_load;
  logic [31:0] freq_word;
  logic [31:0] phase_ofs;
  logic [1:0]  wave_sel;
  logic [7:0]  amp;
  logic        phase_rst;
  logic        en;
  logic [13:0] da_data;
  logic        da_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit [31:0] m_acc, m_fw, m_ofs;
  int        m_sel, m_amp;
  int        dd [4];
  bit        dv [4];
  bit        dk [4];
  int        sc_d;
  bit        sc_v, sc_k;
  int        hist [$];

  dds_multiwave #(
    .PHASE_W (32),
    .ADDR_W  (10),
    .DATA_W  (14)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cfg_load  (cfg_load),
    .freq_word (freq_word),
    .phase_ofs (phase_ofs),
    .wave_sel  (wave_sel),
    .amp       (amp),
    .phase_rst (phase_rst),
    .en        (en),
    .da_data   (da_data),
    .da_valid  (da_valid)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ideal waveform value at a 32-bit phase, 14-bit offset-binary output
  function automatic int wave_ref(input int sel, input bit [31:0] ph);
    int t, q, idx, i, mag;
    t   = int'(ph >> 18);
    q   = int'(ph >> 30);
    idx = int'((ph >> 20) & 32'h3FF);
    case (sel)
      0: begin
        i   = (q % 2 == 1) ? 1023 - idx : idx;
        mag = $rtoi(8191.0 * $sin(PI_R / 2.0 * (real'(i) + 0.5) / 1024.0) + 0.5);
        return (q >= 2) ? 8191 - mag : 8192 + mag;
      end
      1:       return (ph < 32'h8000_0000) ? 16383 : 0;
      2:       return t;
      default: return (t < 8192) ? 2 * t : 16383 - 2 * (t - 8192);
    endcase
  endfunction

  function automatic int scale(input int x, input int a);
    int p;
    p = (x - 8192) * a;
    return 8192 + ((p >= 0) ? p / 256 : -((-p + 255) / 256));
  endfunction

  function automatic int fin(input int x);
`ifdef DDS_AMP_SCALE_EN
    return scale(x, m_amp);
`else
    return x;
`endif
  endfunction

  function automatic int hget(input int i);
    if (i < hist.size()) return hist[i];
    return -1;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_fw = 0; m_ofs = 0; m_sel = 0; m_amp = 0;
    for (int i = 0; i < 4; i++) begin
      dd[i] = 8192; dv[i] = 1'b0; dk[i] = 1'b0;
    end
    sc_d = 8192; sc_v = 1'b0; sc_k = 1'b0;
  endtask

  task automatic model_edge();
    if (sys_rst) begin
      model_reset();
    end else begin
      sc_d = scale(dd[3], m_amp); sc_v = dv[3]; sc_k = dk[3];
      if (phase_rst)  m_acc = 0;
      else if (en)    m_acc = m_acc + m_fw;
      if (cfg_load) begin
        m_fw = freq_word; m_ofs = phase_ofs; m_sel = int'(wave_sel); m_amp = int'(amp);
      end
      for (int i = 3; i > 0; i--) begin
        dd[i] = dd[i-1]; dv[i] = dv[i-1]; dk[i] = dk[i-1];
      end
      dd[0] = wave_ref(m_sel, m_acc + m_ofs);
      dv[0] = en;
      dk[0] = 1'b1;
    end
  endtask

  task automatic tick();
    int  ed;
    bit  ev, ek;
    @(posedge sys_clk);
    model_edge();
    #1;
`ifdef DDS_AMP_SCALE_EN
    ed = sc_d; ev = sc_v; ek = sc_k;
`else
    ed = dd[3]; ev = dv[3]; ek = dk[3];
`endif
    check("da_valid", 32'(da_valid), 32'(ev));
    if (ek) check("da_data", 32'(da_data), 32'(ed));
    if (da_valid) hist.push_back(int'(da_data));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Drain, then load a new word with a simultaneous phase clear and enable
  task automatic start(input bit [31:0] fw, input bit [31:0] ofs, input int sel, input int a);
    en = 1'b0; cfg_load = 1'b0; phase_rst = 1'b0;
    run(6);
    hist.delete();
    freq_word = fw; phase_ofs = ofs; wave_sel = 2'(sel); amp = 8'(a);
    cfg_load = 1'b1; phase_rst = 1'b1; en = 1'b1;
    tick();
    cfg_load = 1'b0; phase_rst = 1'b0;
  endtask

  initial begin
    int mx, mn;
    sys_rst = 1'b1; cfg_load = 1'b0; freq_word = '0; phase_ofs = '0;
    wave_sel = '0; amp = '0; phase_rst = 1'b0; en = 1'b0;
    model_reset();
    #1;
    check("reset_data", 32'(da_data), 32'd8192);
    check("reset_valid", 32'(da_valid), 32'd0);
    run(2);
    sys_rst = 1'b0;

    // sine at 1024 samples per period
    start(32'h0040_0000, 32'h0, 0, 255);
    run(1100);
    check("sine_first", 32'(hget(0)), 32'(fin(8198)));
    check("sine_256", 32'(hget(256)), 32'(fin(16383)));
    check("sine_512", 32'(hget(512)), 32'(fin(8185)));
    check("sine_768", 32'(hget(768)), 32'(fin(0)));
    check("sine_period", 32'(hget(1024)), 32'(fin(8198)));

    // constant output at quarter-phase offset, valid latency
    start(32'h0, 32'h4000_0000, 0, 255);
    run(LAT - 1);
    check("valid_lat_pre", 32'(da_valid), 32'd0);
    tick();
    check("valid_lat", 32'(da_valid), 32'd1);
    run(20);
    check("const_first", 32'(hget(0)), 32'(fin(16383)));
    check("const_later", 32'(hget(15)), 32'(fin(16383)));

    // square at Nyquist
    start(32'h8000_0000, 32'h0, 1, 255);
    run(20);
    check("square_0", 32'(hget(0)), 32'(fin(16383)));
    check("square_1", 32'(hget(1)), 32'(fin(0)));
    check("square_2", 32'(hget(2)), 32'(fin(16383)));

    // sawtooth full ramp with wrap
    start(32'h0004_0000, 32'h0, 2, 255);
    run(16400);
    check("saw_1", 32'(hget(1)), 32'(fin(1)));
    check("saw_8192", 32'(hget(8192)), 32'(fin(8192)));
    check("saw_top", 32'(hget(16383)), 32'(fin(16383)));
    check("saw_wrap", 32'(hget(16384)), 32'(fin(0)));

    // triangle rise and fall
    start(32'h0004_0000, 32'h0, 3, 255);
    run(16400);
    check("tri_1", 32'(hget(1)), 32'(fin(2)));
    check("tri_peak_up", 32'(hget(8191)), 32'(fin(16382)));
    check("tri_peak_dn", 32'(hget(8192)), 32'(fin(16383)));
    check("tri_end", 32'(hget(16383)), 32'(fin(1)));
    check("tri_wrap", 32'(hget(16384)), 32'(fin(0)));

    // freeze with enable low
    en = 1'b0;
    run(LAT + 2);
    check("freeze_data", 32'(da_data), 32'(fin(wave_ref(m_sel, m_acc + m_ofs))));
    check("freeze_valid", 32'(da_valid), 32'd0);
    run(3);
    check("freeze_hold", 32'(da_data), 32'(fin(wave_ref(m_sel, m_acc + m_ofs))));

    // asynchronous reset in the middle of a run
    start(32'h0123_4567, 32'h0, 2, 255);
    run(50);
    #3;
    sys_rst = 1'b1;
    model_reset();
    #1;
    check("midrst_data", 32'(da_data), 32'd8192);
    check("midrst_valid", 32'(da_valid), 32'd0);
    run(2);
    sys_rst = 1'b0;
    run(3);

`ifdef DDS_AMP_SCALE_EN
    // half gain on full-scale sine
    start(32'h0040_0000, 32'h0, 0, 128);
    run(1100);
    mx = 0; mn = 16383;
    foreach (hist[i]) begin
      if (hist[i] > mx) mx = hist[i];
      if (hist[i] < mn) mn = hist[i];
    end
    check("amp_peak", 32'(mx), 32'd12287);
    check("amp_trough", 32'(mn), 32'd4096);
`else
    mx = 0; mn = 0;
`endif

    // randomized configuration traffic
    for (int k = 0; k < 3000; k++) begin
      cfg_load  = ($urandom_range(0, 15) == 0);
      phase_rst = ($urandom_range(0, 63) == 0);
      en        = ($urandom_range(0, 7) != 0);
      freq_word = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> $urandom_range(4, 20));
      phase_ofs = $urandom;
      wave_sel  = 2'($urandom_range(0, 3));
      amp       = 8'($urandom_range(0, 255));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
